// File: rtl/jpeg_cone_eval_arbiter_if.sv
// Request/response bundle between the cone-evaluator requesters and the shared arbiter.
// master = requester/downstream side, slave = arbiter side.
interface jpeg_cone_eval_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*5*W-1:0]   req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [W-1:0]          rsp_data;
  logic [IDW-1:0]        rsp_id;

  modport master (
    output req_valid, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/jpeg_cone_eval_arbiter.sv
// Shares one registered AOI cone evaluator Y = ~((l0&l1&l2)|(l3&l4)) among NREQ requesters,
// with round-robin or fixed-priority arbitration and a backpressured, ID-tagged response.
module jpeg_cone_eval_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_rr_en,
  jpeg_cone_eval_arbiter_if.slave   bus,
  output logic                      busy
);

  logic [IDW-1:0]   ptr_r;
  logic             rsp_valid_r;
  logic [W-1:0]     rsp_data_r;
  logic [IDW-1:0]   rsp_id_r;

  logic             can_issue_s;
  logic             found_s;
  logic [IDW-1:0]   idx_s;
  logic [IDW-1:0]   grant_id_s;
  logic             transfer_s;
  logic [NREQ-1:0]  req_ready_s;
  logic [5*W-1:0]   lanes_s;

  function automatic logic [W-1:0] cone_eval(input logic [5*W-1:0] lanes);
    logic [W-1:0] l0, l1, l2, l3, l4;
    l0 = lanes[0*W +: W];
    l1 = lanes[1*W +: W];
    l2 = lanes[2*W +: W];
    l3 = lanes[3*W +: W];
    l4 = lanes[4*W +: W];
    return ~((l0 & l1 & l2) | (l3 & l4));
  endfunction

  // Winner search: rotating start after the last grant, or plain lowest index.
  always_comb begin
    can_issue_s = ~rsp_valid_r | bus.rsp_ready;
    found_s     = 1'b0;
    grant_id_s  = '0;
    idx_s       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (cfg_rr_en) begin
        idx_s = IDW'((int'(ptr_r) + 1 + i) % NREQ);
      end else begin
        idx_s = IDW'(i);
      end
      if (!found_s && bus.req_valid[idx_s]) begin
        found_s    = 1'b1;
        grant_id_s = idx_s;
      end else begin
        found_s    = found_s;
      end
    end
    transfer_s = found_s & can_issue_s & ~rst;
  end

  // One-hot accept and operand mux for the winning requester.
  always_comb begin
    req_ready_s = '0;
    lanes_s     = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (transfer_s && (grant_id_s == IDW'(r))) begin
        req_ready_s[r] = 1'b1;
        lanes_s        = bus.req_op[r*5*W +: 5*W];
      end else begin
        req_ready_s[r] = 1'b0;
      end
    end
  end

  // Response register and round-robin pointer; a pop without a new transfer keeps data/id.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_id_r    <= '0;
      ptr_r       <= IDW'(NREQ - 1);
    end else if (transfer_s) begin
      rsp_valid_r <= 1'b1;
      rsp_data_r  <= cone_eval(lanes_s);
      rsp_id_r    <= grant_id_s;
      ptr_r       <= grant_id_s;
    end else if (bus.rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_id    = rsp_id_r;
  assign busy          = rsp_valid_r | (|bus.req_valid);

endmodule

// File: tb/tb_jpeg_cone_eval_arbiter.sv
// Directed bench for jpeg_cone_eval_arbiter: reset, datapath, round-robin, fixed priority,
// backpressure and mid-operation reset, with hand-computed expectations.
module tb_jpeg_cone_eval_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic clk;
  logic rst;
  logic cfg_rr_en;
  logic busy;

  int n_cmp;
  int n_bad;

  jpeg_cone_eval_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

  jpeg_cone_eval_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_rr_en (cfg_rr_en),
    .bus       (bus),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input int r, input logic [7:0] l0, input logic [7:0] l1,
                           input logic [7:0] l2, input logic [7:0] l3, input logic [7:0] l4);
    bus.req_op[r*5*W +: 5*W] = {l4, l3, l2, l1, l0};
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    rst           = 1'b1;
    cfg_rr_en     = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();

    // Reset state: nothing accepted while rst is high.
    check_eq("rst_ready", 32'(bus.req_ready), 32'h0);
    check_eq("rst_valid", 32'(bus.rsp_valid), 32'h0);
    check_eq("rst_data",  32'(bus.rsp_data),  32'h0);
    check_eq("rst_id",    32'(bus.rsp_id),    32'h0);
    rst           = 1'b0;
    bus.req_valid = 4'b0000;
    #1;
    check_eq("idle_busy", 32'(busy), 32'h0);

    // Single requester 0: ~((FF&FF&FF)|(0F&F0)) = 00
    set_lanes(0, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'hF0);
    bus.req_valid = 4'b0001;
    #1;
    check_eq("t1_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 4'b0000;
    #1;
    check_eq("t1_valid", 32'(bus.rsp_valid), 32'h1);
    check_eq("t1_data",  32'(bus.rsp_data),  32'h00);
    check_eq("t1_id",    32'(bus.rsp_id),    32'h0);
    check_eq("t1_busy",  32'(busy),          32'h1);

    // Single requester 2: ~(0A|11) = E4
    set_lanes(2, 8'hAA, 8'hFF, 8'h0F, 8'h33, 8'h11);
    bus.req_valid = 4'b0100;
    #1;
    check_eq("t2_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 4'b0000;
    check_eq("t2_data", 32'(bus.rsp_data), 32'hE4);
    check_eq("t2_id",   32'(bus.rsp_id),   32'h2);
    tick();
    // Pop with no new transfer: valid drops, data/id retained.
    check_eq("pop_valid", 32'(bus.rsp_valid), 32'h0);
    check_eq("pop_data",  32'(bus.rsp_data),  32'hE4);
    check_eq("pop_id",    32'(bus.rsp_id),    32'h2);

    // Round-robin fairness from a fresh pointer.
    rst = 1'b1;
    tick();
    rst           = 1'b0;
    cfg_rr_en     = 1'b1;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq($sformatf("rr_ready%0d", i), 32'(bus.req_ready), 32'(1 << (i % 4)));
      tick();
      check_eq($sformatf("rr_id%0d", i), 32'(bus.rsp_id), 32'(i % 4));
    end

    // Fixed priority: lowest valid index wins every cycle.
    cfg_rr_en     = 1'b0;
    bus.req_valid = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("fp_ready%0d", i), 32'(bus.req_ready), 32'h2);
      tick();
      check_eq($sformatf("fp_id%0d", i), 32'(bus.rsp_id), 32'h1);
    end
    bus.req_valid = 4'b1100;
    #1;
    check_eq("fp_drop_ready", 32'(bus.req_ready), 32'h4);
    tick();
    check_eq("fp_drop_id", 32'(bus.rsp_id), 32'h2);

    // Backpressure: pointer is 2, so RR picks 0 then 1.  Req1 lanes: ~(F0|00) = 0F
    cfg_rr_en = 1'b1;
    set_lanes(1, 8'hF0, 8'hFF, 8'hFF, 8'h00, 8'h00);
    bus.req_valid = 4'b0011;
    #1;
    check_eq("bp_ready0", 32'(bus.req_ready), 32'h1);
    tick();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("bp_hold_ready%0d", i), 32'(bus.req_ready), 32'h0);
      check_eq($sformatf("bp_hold_valid%0d", i), 32'(bus.rsp_valid), 32'h1);
      check_eq($sformatf("bp_hold_data%0d", i),  32'(bus.rsp_data),  32'h00);
      check_eq($sformatf("bp_hold_id%0d", i),    32'(bus.rsp_id),    32'h0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(bus.req_ready), 32'h2);
    tick();
    check_eq("bp_next_valid", 32'(bus.rsp_valid), 32'h1);
    check_eq("bp_next_id",    32'(bus.rsp_id),    32'h1);
    check_eq("bp_next_data",  32'(bus.rsp_data),  32'h0F);

    // Reset with a stalled response pending.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    rst           = 1'b1;
    #1;
    check_eq("mrst_ready_in_rst", 32'(bus.req_ready), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("mrst_valid", 32'(bus.rsp_valid), 32'h0);
    check_eq("mrst_id",    32'(bus.rsp_id),    32'h0);
    check_eq("mrst_ready", 32'(bus.req_ready), 32'h1);
    tick();
    check_eq("mrst_first_valid", 32'(bus.rsp_valid), 32'h1);
    check_eq("mrst_first_id",    32'(bus.rsp_id),    32'h0);
    check_eq("mrst_first_data",  32'(bus.rsp_data),  32'h00);

    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b1;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
